// File: rtl/argmax_fix9.sv
// argmax_fix9: sequential argmax over NUM_CLASSES signed fixed-point scores.
// On a start pulse the block walks out_idx from 0 to NUM_CLASSES-1, reading the
// score for each index from the upstream selector on the same cycle. It keeps a
// running maximum in which ties go to the lower index. After the last index it
// publishes digit/max_val together with a one-cycle valid pulse.
// Optional feature: define ARGMAX_MARGIN_EN to add a 'margin' output, which is
// the winning score minus the second-highest score.
module argmax_fix9 #(
    parameter int DATA_WIDTH  = 9,
    parameter int NUM_CLASSES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reset,
    input  logic                  start,
    output logic [3:0]            out_idx,
    input  logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  valid,
    output logic [3:0]            digit,
    output logic [DATA_WIDTH-1:0] max_val
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_WIDTH:0]   margin
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] score;
    logic signed [DATA_WIDTH-1:0] run_max;
    logic        [3:0]            run_idx;
    logic signed [DATA_WIDTH-1:0] nxt_max;
    logic        [3:0]            nxt_idx;
    logic                         take;

    assign score = $signed(out);

    // Running-max update for the score sampled this cycle. The first index loads
    // unconditionally. Later indexes replace the max only on a strict signed win.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        take    = (out_idx == 4'd0) || (score > run_max);
        nxt_max = run_max;
        nxt_idx = run_idx;
        if (take) begin
            nxt_max = score;
            nxt_idx = out_idx;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] run_second;
    logic signed [DATA_WIDTH-1:0] nxt_second;
    logic        [DATA_WIDTH:0]   nxt_margin;

    // Second-best tracking. A dethroned max becomes the second; otherwise a strict
    // win over the current second replaces it. A tie with the max therefore
    // lands in second and gives a margin of 0.
    always_comb begin
        nxt_second = run_second;
        if (out_idx == 4'd0) begin
            nxt_second = MIN_SCORE;
        end else if (score > run_max) begin
            nxt_second = run_max;
        end else if (score > run_second) begin
            nxt_second = score;
        end
    end

    // The difference is taken one bit wider, so the full signed range gives a non-negative result.
    assign nxt_margin = {nxt_max[DATA_WIDTH-1], nxt_max} - {nxt_second[DATA_WIDTH-1], nxt_second};
`endif

    // Scan FSM with registered outputs. The result is loaded on the edge that
    // enters DONE, so digit/max_val become visible in the same cycle as valid.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            out_idx <= 4'd0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            digit   <= 4'd0;
            max_val <= '0;
            run_max <= '0;
            run_idx <= 4'd0;
`ifdef ARGMAX_MARGIN_EN
            run_second <= '0;
            margin     <= '0;
`endif
        end else if (reset) begin
            state   <= IDLE;
            out_idx <= 4'd0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            digit   <= 4'd0;
            max_val <= '0;
            run_max <= '0;
            run_idx <= 4'd0;
`ifdef ARGMAX_MARGIN_EN
            run_second <= '0;
            margin     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid   <= 1'b0;
                    out_idx <= 4'd0;
                    busy    <= 1'b0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    run_max <= nxt_max;
                    run_idx <= nxt_idx;
`ifdef ARGMAX_MARGIN_EN
                    run_second <= nxt_second;
`endif
                    if (out_idx == LAST_IDX) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        out_idx <= 4'd0;
                        digit   <= nxt_idx;
                        max_val <= nxt_max;
`ifdef ARGMAX_MARGIN_EN
                        margin  <= nxt_margin;
`endif
                    end else begin
                        out_idx <= out_idx + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    out_idx <= 4'd0;
                end
                default: begin
                    state   <= IDLE;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    out_idx <= 4'd0;
                end
            endcase
        end
    end

endmodule
